// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one two-phase SRAM-like memory port between fetch and data requesters
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_req,
    input  logic [ADDR_W-1:0]     inst_addr,
    input  logic                  inst_cancel,
    output logic                  inst_addr_ok,
    output logic                  inst_data_ok,
    output logic [DATA_W-1:0]     inst_rdata,
    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [1:0]            data_size,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic [DATA_W-1:0]     data_wdata,
    input  logic [DATA_W/8-1:0]   data_wstrb,
    output logic                  data_addr_ok,
    output logic                  data_data_ok,
    output logic [DATA_W-1:0]     data_rdata,
    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [1:0]            mem_size,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_addr_ok,
    input  logic                  mem_data_ok,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy
);

    typedef enum logic [2:0] {IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA} state_t;

    state_t state, state_nxt;
    logic   last_grant_data;
    logic   drop;
    logic   inst_elig;
    logic   prefer_data;
    logic   grant_inst;
    logic   grant_data;

    // Grants only happen in IDLE; the addr_ok pulses are the grants themselves.
    always_comb begin
        inst_elig   = inst_req & ~inst_cancel;
        prefer_data = (ROUND_ROBIN == 0) || !last_grant_data;
        grant_data  = 1'b0;
        grant_inst  = 1'b0;
        if (state == IDLE && !rst) begin
            grant_data = data_req && (!inst_elig || prefer_data);
            grant_inst = inst_elig && !grant_data;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_data)      state_nxt = D_ADDR;
                else if (grant_inst) state_nxt = I_ADDR;
            end
            I_ADDR:  if (mem_addr_ok) state_nxt = I_DATA;
            I_DATA:  if (mem_data_ok) state_nxt = IDLE;
            D_ADDR:  if (mem_addr_ok) state_nxt = D_DATA;
            D_DATA:  if (mem_data_ok) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;
    assign busy         = (state != IDLE);

    // The mem_* registers double as the latched copy of the granted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            last_grant_data <= 1'b0;
            drop            <= 1'b0;
            mem_req         <= 1'b0;
            mem_wr          <= 1'b0;
            mem_size        <= 2'd0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            mem_wstrb       <= '0;
            inst_data_ok    <= 1'b0;
            data_data_ok    <= 1'b0;
            inst_rdata      <= '0;
            data_rdata      <= '0;
        end else begin
            state        <= state_nxt;
            inst_data_ok <= 1'b0;
            data_data_ok <= 1'b0;

            if (grant_data) begin
                last_grant_data <= 1'b1;
                mem_req         <= 1'b1;
                mem_wr          <= data_wr;
                mem_size        <= data_size;
                mem_addr        <= data_addr;
                mem_wdata       <= data_wdata;
                mem_wstrb       <= data_wstrb;
            end else if (grant_inst) begin
                last_grant_data <= 1'b0;
                mem_req         <= 1'b1;
                mem_wr          <= 1'b0;
                mem_size        <= 2'd2;
                mem_addr        <= inst_addr;
                mem_wdata       <= '0;
                mem_wstrb       <= '0;
            end else if ((state == I_ADDR || state == D_ADDR) && mem_addr_ok) begin
                mem_req <= 1'b0;
            end

            if ((state == I_ADDR || state == I_DATA) && inst_cancel)
                drop <= 1'b1;
            if (state_nxt == IDLE)
                drop <= 1'b0;

            // A cancel landing in the same cycle as the response still discards it.
            if (state == I_DATA && mem_data_ok && !drop && !inst_cancel) begin
                inst_data_ok <= 1'b1;
                inst_rdata   <= mem_rdata;
            end

            if (state == D_DATA && mem_data_ok) begin
                data_data_ok <= 1'b1;
                if (!mem_wr)
                    data_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        inst_req, inst_cancel;
    logic [31:0] inst_addr;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;

    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, busy;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    logic        b_inst_addr_ok, b_inst_data_ok, b_data_addr_ok, b_data_data_ok;
    logic [31:0] b_inst_rdata, b_data_rdata;
    logic        b_mem_req, b_mem_wr, b_mem_addr_ok, b_mem_data_ok, b_busy;
    logic [1:0]  b_mem_size;
    logic [31:0] b_mem_addr, b_mem_wdata;
    logic [3:0]  b_mem_wstrb;
    logic [31:0] b_mem_rdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(1)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(0)) dut_fixed (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
        .inst_addr_ok(b_inst_addr_ok), .inst_data_ok(b_inst_data_ok), .inst_rdata(b_inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_addr_ok(b_data_addr_ok), .data_data_ok(b_data_data_ok), .data_rdata(b_data_rdata),
        .mem_req(b_mem_req), .mem_wr(b_mem_wr), .mem_size(b_mem_size), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_wstrb(b_mem_wstrb),
        .mem_addr_ok(b_mem_addr_ok), .mem_data_ok(b_mem_data_ok), .mem_rdata(b_mem_rdata),
        .busy(b_busy)
    );

    // Memory model: a_dly wait cycles before accepting the address, d_dly before responding.
    int   addr_delay, data_delay, a_cnt, d_cnt;
    logic pend, spur;
    always @(posedge clk) begin
        if (rst) begin
            a_cnt <= 0; d_cnt <= 0; pend <= 1'b0;
        end else begin
            a_cnt <= (mem_req && !mem_addr_ok) ? a_cnt + 1 : 0;
            if (mem_req && mem_addr_ok) begin
                pend <= 1'b1; d_cnt <= 0;
            end else if (mem_data_ok) begin
                pend <= 1'b0;
            end else if (pend) begin
                d_cnt <= d_cnt + 1;
            end
        end
    end
    assign mem_addr_ok = mem_req && (a_cnt >= addr_delay);
    assign mem_data_ok = (pend && (d_cnt >= data_delay)) || spur;

    logic b_pend;
    always @(posedge clk) b_pend <= rst ? 1'b0 : b_mem_req;
    assign b_mem_addr_ok = b_mem_req;
    assign b_mem_data_ok = b_pend;
    assign b_mem_rdata   = 32'h0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        checks++;
        if ((inst_addr_ok && data_addr_ok) || (inst_data_ok && data_data_ok) ||
            (b_inst_addr_ok && b_data_addr_ok) || (b_inst_data_ok && b_data_data_ok)) begin
            errors++;
            $display("FAIL exclusivity at %0t actual=both-high required=one-high", $time);
        end
    end

    typedef struct {
        logic        is_data;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] mem_rd;
        int          a_dly;
        int          d_dly;
        logic        exp_wr;
        logic [1:0]  exp_size;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_rdata;
        logic [31:0] exp_other_rdata;
        int          exp_done;
    } vec_t;

    vec_t vecs[6];
    vec_t refetch;

    // Starts at posedge+1 with the bench idle; ends at posedge+1 with the DUT idle.
    task automatic run_txn(input vec_t v, input string tag);
        int          mreq_cnt, dok_cnt, done_at, first_at;
        logic        seen, stable, other_dok;
        logic [31:0] s_addr;
        logic [38:0] s_ctl;
        addr_delay = v.a_dly;
        data_delay = v.d_dly;
        mem_rdata  = v.mem_rd;
        if (v.is_data) begin
            data_req = 1'b1; data_wr = v.wr; data_size = v.size; data_addr = v.addr;
            data_wdata = v.wdata; data_wstrb = v.wstrb;
        end else begin
            inst_req = 1'b1; inst_addr = v.addr;
        end
        @(negedge clk);
        check({tag, " addr_ok"}, 64'(v.is_data ? data_addr_ok : inst_addr_ok), 64'(1));
        check({tag, " other addr_ok"}, 64'(v.is_data ? inst_addr_ok : data_addr_ok), 64'(0));
        @(posedge clk); #1;
        inst_req = 1'b0; data_req = 1'b0;
        mreq_cnt = 0; dok_cnt = 0; done_at = -1; first_at = -1;
        seen = 1'b0; stable = 1'b1; other_dok = 1'b0; s_addr = '0; s_ctl = '0;
        for (int cyc = 1; cyc <= v.exp_done + 1; cyc++) begin
            @(negedge clk);
            if (mem_req) begin
                if (!seen) begin
                    seen = 1'b1; first_at = cyc;
                    s_addr = mem_addr; s_ctl = {mem_wr, mem_size, mem_wdata, mem_wstrb};
                end else if (s_addr !== mem_addr || s_ctl !== {mem_wr, mem_size, mem_wdata, mem_wstrb}) begin
                    stable = 1'b0;
                end
                mreq_cnt++;
            end
            if (v.is_data ? data_data_ok : inst_data_ok) begin
                dok_cnt++; done_at = cyc;
            end
            if (v.is_data ? inst_data_ok : data_data_ok) other_dok = 1'b1;
        end
        check({tag, " mem_req first cycle"}, 64'(first_at), 64'(1));
        check({tag, " mem_addr"}, 64'(s_addr), 64'(v.addr));
        check({tag, " mem wr/size/wdata/wstrb"}, 64'(s_ctl), 64'({v.exp_wr, v.exp_size, v.exp_wdata, v.exp_wstrb}));
        check({tag, " mem_req cycles"}, 64'(mreq_cnt), 64'(v.a_dly + 1));
        check({tag, " mem fields stable"}, 64'(stable), 64'(1));
        check({tag, " data_ok count"}, 64'(dok_cnt), 64'(1));
        check({tag, " data_ok cycle"}, 64'(done_at), 64'(v.exp_done));
        check({tag, " rdata"}, 64'(v.is_data ? data_rdata : inst_rdata), 64'(v.exp_rdata));
        check({tag, " other rdata"}, 64'(v.is_data ? inst_rdata : data_rdata), 64'(v.exp_other_rdata));
        check({tag, " other data_ok"}, 64'(other_dok), 64'(0));
        check({tag, " busy after"}, 64'(busy), 64'(0));
        @(posedge clk); #1;
    endtask

    int   g_side[4], g_cyc[4], b_side[4], b_cyc[4];
    int   gn, bn;
    logic saw_ok;

    initial begin
        rst = 1'b1; inst_req = 1'b0; inst_cancel = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_addr = '0; data_wdata = '0; data_wstrb = '0;
        addr_delay = 0; data_delay = 0; spur = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset ctl", 64'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, mem_req, mem_wr, busy}), 64'(0));
        check("reset mem bus", 64'({mem_size, mem_addr, mem_wstrb}), 64'(0));
        check("reset wdata/rdata", 64'({mem_wdata, inst_rdata | data_rdata}), 64'(0));
        @(posedge clk); #1;

        //            is_d wr  size  addr          wdata         wstrb mem_rd        a  d  ewr esz   ewdata        estrb erdata        eother        done
        vecs[0] = '{1'b0, 1'b0, 2'd0, 32'hBFC00000, 32'h0,        4'h0, 32'h3C1D8000, 0, 0, 1'b0, 2'd2, 32'h0,        4'h0, 32'h3C1D8000, 32'h0,        3};
        vecs[1] = '{1'b1, 1'b1, 2'd0, 32'h80001003, 32'h000000AB, 4'h8, 32'hDEADBEEF, 0, 0, 1'b1, 2'd0, 32'h000000AB, 4'h8, 32'h0,        32'h3C1D8000, 3};
        vecs[2] = '{1'b1, 1'b0, 2'd2, 32'h80002000, 32'h0,        4'h0, 32'hCAFEF00D, 0, 0, 1'b0, 2'd2, 32'h0,        4'h0, 32'hCAFEF00D, 32'h3C1D8000, 3};
        vecs[3] = '{1'b0, 1'b0, 2'd0, 32'hBFC00010, 32'h0,        4'h0, 32'h11223344, 4, 5, 1'b0, 2'd2, 32'h0,        4'h0, 32'h11223344, 32'hCAFEF00D, 12};
        vecs[4] = '{1'b1, 1'b1, 2'd1, 32'h80003002, 32'h5A5A0000, 4'hC, 32'h99999999, 2, 1, 1'b1, 2'd1, 32'h5A5A0000, 4'hC, 32'hCAFEF00D, 32'h11223344, 6};
        vecs[5] = '{1'b1, 1'b0, 2'd0, 32'h80004001, 32'h0,        4'h2, 32'h0000EE00, 1, 0, 1'b0, 2'd0, 32'h0,        4'h2, 32'h0000EE00, 32'h11223344, 4};
        refetch = '{1'b0, 1'b0, 2'd0, 32'hBFC00024, 32'h0,        4'h0, 32'h0BADC0DE, 0, 0, 1'b0, 2'd2, 32'h0,        4'h0, 32'h0BADC0DE, 32'h0000EE00, 3};

        for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Cancel while in I_DATA: response arrives two cycles later and must be dropped.
        addr_delay = 0; data_delay = 2; mem_rdata = 32'h12345678;
        inst_req = 1'b1; inst_addr = 32'hBFC00020;
        @(negedge clk);
        check("cancel addr_ok", 64'(inst_addr_ok), 64'(1));
        @(posedge clk); #1 inst_req = 1'b0;
        @(posedge clk); #1 inst_cancel = 1'b1;
        @(posedge clk); #1 inst_cancel = 1'b0;
        saw_ok = 1'b0;
        for (int cyc = 3; cyc <= 7; cyc++) begin
            @(negedge clk);
            if (inst_data_ok) saw_ok = 1'b1;
            if (cyc == 4) check("cancel busy in I_DATA", 64'(busy), 64'(1));
            if (cyc == 5) check("cancel busy falls", 64'(busy), 64'(0));
        end
        check("cancel no data_ok", 64'(saw_ok), 64'(0));
        check("cancel rdata kept", 64'(inst_rdata), 64'(32'h11223344));
        @(posedge clk); #1;
        run_txn(refetch, "refetch");

        inst_req = 1'b1; inst_cancel = 1'b1; inst_addr = 32'hBFC00030;
        @(negedge clk);
        check("idle cancel blocks grant", 64'(inst_addr_ok), 64'(0));
        @(posedge clk); #1 inst_req = 1'b0; inst_cancel = 1'b0;
        @(negedge clk);
        check("idle cancel stays idle", 64'({busy, mem_req}), 64'(0));
        @(posedge clk); #1 spur = 1'b1;
        @(posedge clk); #1 spur = 1'b0;
        @(negedge clk);
        check("spurious mem_data_ok ignored", 64'({inst_data_ok, data_data_ok, busy}), 64'(0));
        @(posedge clk); #1;

        // Reset while the load waits in D_DATA.
        addr_delay = 0; data_delay = 5; mem_rdata = 32'h77777777;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h80006000; data_wstrb = 4'h0;
        @(negedge clk);
        check("rst-mid addr_ok", 64'(data_addr_ok), 64'(1));
        @(posedge clk); #1 data_req = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("rst-mid in D_DATA", 64'({busy, mem_req}), 64'(2'b10));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst-mid ctl cleared", 64'({busy, mem_req, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}), 64'(0));
        check("rst-mid rdata cleared", 64'({inst_rdata, data_rdata}), 64'(0));
        @(posedge clk); #1;

        // Contention from reset state: both sides request continuously.
        addr_delay = 0; data_delay = 0;
        inst_req = 1'b1; inst_addr = 32'hBFC00100;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h80007000;
        gn = 0; bn = 0;
        for (int cyc = 0; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (gn < 4 && (inst_addr_ok || data_addr_ok)) begin
                g_side[gn] = data_addr_ok ? 1 : 0; g_cyc[gn] = cyc; gn++;
            end
            if (bn < 4 && (b_inst_addr_ok || b_data_addr_ok)) begin
                b_side[bn] = b_data_addr_ok ? 1 : 0; b_cyc[bn] = cyc; bn++;
            end
        end
        @(posedge clk); #1 inst_req = 1'b0; data_req = 1'b0;
        check("rr grant count", 64'(gn), 64'(4));
        check("fixed grant count", 64'(bn), 64'(4));
        for (int k = 0; k < 4; k++) begin
            if (k < gn) check($sformatf("rr grant %0d side/cycle", k), 64'({g_side[k], g_cyc[k]}), 64'({(k % 2 == 0) ? 1 : 0, 3 * k}));
            if (k < bn) check($sformatf("fixed grant %0d side/cycle", k), 64'({b_side[k], b_cyc[k]}), 64'({1, 3 * k}));
        end

        for (int t = 0; t < 20 && (busy || b_busy); t++) @(posedge clk);
        #1;
        check("final idle", 64'({busy, b_busy}), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
